camera_capture: RTL and testbench



---
 rtl/camera_capture_pkg.sv | 42 ++++
 rtl/camera_capture_sync_edge_detect.sv | 31 +++
 rtl/camera_capture.sv | 164 ++++++++++++++++
 tb/tb_camera_capture.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_capture_pkg.sv
// Shared types and constants for the camera capture path: default frame
// geometry, RGB444/RGB332 field layout, FSM state encoding and the colour
// conversion used when a pixel is written to the frame buffer.
package camera_capture_pkg;

    localparam int WIDTH_DEF  = 176;
    localparam int HEIGHT_DEF = 144;
    localparam int ADDR_W_DEF = 15;

    // Nibble positions inside the two camera bytes of one RGB444 pixel.
    localparam int EVEN_R_LSB = 0;   // even byte = {don't care, R}
    localparam int ODD_G_LSB  = 4;   // odd byte  = {G, B}
    localparam int ODD_B_LSB  = 0;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        VBLANK  = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Keep the most significant bits of each channel.
    function automatic rgb332_t rgb444_to_rgb332(input rgb444_t p);
        rgb332_t q;
        q.r = p.r[3:1];
        q.g = p.g[3:1];
        q.b = p.b[3:2];
        return q;
    endfunction

endpackage

// File: rtl/camera_capture_sync_edge_detect.sv
// Registers VSYNC/HREF once and reports their edges. The raw inputs are
// passed through undelayed to the rest of the capture logic; only the
// edge pulses depend on the registered copies.
module camera_capture_sync_edge_detect (
    input  logic CLK,
    input  logic RESET_N,
    input  logic VSYNC,
    input  logic HREF,
    output logic vsync_rise,
    output logic href_fall
);

    logic vsync_q;
    logic href_q;

    // One-cycle history of the sync inputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            vsync_q <= VSYNC;
            href_q  <= HREF;
        end
    end

    assign vsync_rise = VSYNC & ~vsync_q;
    assign href_fall  = ~HREF & href_q;

endmodule

// File: rtl/camera_capture.sv
// Camera byte-stream capture: assembles RGB444 pixels (high byte first),
// converts them to RGB332 and writes them to the frame buffer at
// row_base + x. Optional macro COLOR_STATS_EN adds per-frame red/blue
// pixel counters on RED_CNT/BLUE_CNT.
module camera_capture
    import camera_capture_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        DATA,
    output logic              W_EN,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        W_DATA,
    output logic              FRAME_DONE,
    output logic              ROW_ERR
`ifdef COLOR_STATS_EN
    ,
    output logic [ADDR_W-1:0] RED_CNT,
    output logic [ADDR_W-1:0] BLUE_CNT
`endif
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);

    state_t            state, state_next;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] row_base;
    logic              phase;
    logic [3:0]        red_lat;
    logic              vsync_rise, href_fall;

    logic              clear, capture, row_end, fdone, pix_write;
    rgb444_t           pix;

    camera_capture_sync_edge_detect u_edges (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .VSYNC      (VSYNC),
        .HREF       (HREF),
        .vsync_rise (vsync_rise),
        .href_fall  (href_fall)
    );

    // Frame state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= WAIT_VS;
        else          state <= state_next;
    end

    // Next state and per-cycle control decisions.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next = state;
        clear      = 1'b0;
        capture    = 1'b0;
        row_end    = 1'b0;
        fdone      = 1'b0;
        case (state)
            WAIT_VS: if (VSYNC) state_next = VBLANK;
            VBLANK: begin
                clear = 1'b1;
                if (!VSYNC) state_next = ACTIVE;
            end
            ACTIVE: begin
                capture = HREF & ~VSYNC;
                row_end = href_fall;
                // A row closing in the same cycle still counts towards y > 0.
                fdone   = vsync_rise & ((y != '0) | (href_fall & (x != '0)));
                if (VSYNC) state_next = VBLANK;
            end
            default: state_next = WAIT_VS;
        endcase
        pix       = '{r: red_lat, g: DATA[ODD_G_LSB +: 4], b: DATA[ODD_B_LSB +: 4]};
        pix_write = capture & phase & (x < XW'(WIDTH)) & (y < YW'(HEIGHT));
    end

    // Pixel assembly, raster counters and registered write port.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x          <= '0;
            y          <= '0;
            row_base   <= '0;
            phase      <= 1'b0;
            red_lat    <= '0;
            W_EN       <= 1'b0;
            W_ADDR     <= '0;
            W_DATA     <= '0;
            FRAME_DONE <= 1'b0;
            ROW_ERR    <= 1'b0;
        end else begin
            W_EN       <= pix_write;
            FRAME_DONE <= fdone;
            ROW_ERR    <= row_end & phase;
            if (pix_write) begin
                W_ADDR <= row_base + ADDR_W'(x);
                W_DATA <= rgb444_to_rgb332(pix);
            end
            if (clear) begin
                x        <= '0;
                y        <= '0;
                row_base <= '0;
                phase    <= 1'b0;
            end else if (capture) begin
                if (!phase) begin
                    red_lat <= DATA[EVEN_R_LSB +: 4];
                    phase   <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (x < XW'(WIDTH)) x <= x + XW'(1);
                end
            end else if (row_end) begin
                // Dangling even byte is dropped; y stops at HEIGHT so it never wraps.
                x     <= '0;
                phase <= 1'b0;
                if ((x != '0) && (y < YW'(HEIGHT))) begin
                    y        <= y + YW'(1);
                    row_base <= row_base + ADDR_W'(WIDTH);
                end
            end
        end
    end

`ifdef COLOR_STATS_EN
    logic [ADDR_W-1:0] red_acc, blue_acc;
    logic              vblank_entry, is_red, is_blue;

    assign vblank_entry = (state != VBLANK) && (state_next == VBLANK);
    assign is_red       = pix.r[3] & ~pix.g[3] & ~pix.b[3];
    assign is_blue      = pix.b[3] & ~pix.r[3] & ~pix.g[3];

    // Per-frame colour counters, published on FRAME_DONE.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            red_acc  <= '0;
            blue_acc <= '0;
            RED_CNT  <= '0;
            BLUE_CNT <= '0;
        end else begin
            if (fdone) begin
                RED_CNT  <= red_acc;
                BLUE_CNT <= blue_acc;
            end
            if (vblank_entry) begin
                red_acc  <= '0;
                blue_acc <= '0;
            end else if (pix_write) begin
                if (is_red)  red_acc  <= red_acc + ADDR_W'(1);
                if (is_blue) blue_acc <= blue_acc + ADDR_W'(1);
            end
        end
    end
`else
    // Colour statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture: conversion table, full colour-bar
// frame, odd-length row, coincident row end / VSYNC, reset mid-frame and
// overscan clipping. Colour counters are checked when COLOR_STATS_EN is set.
`timescale 1ns/1ps
module tb_camera_capture;

    localparam int W  = 176;
    localparam int H  = 144;
    localparam int AW = 15;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          VSYNC = 1'b0;
    logic          HREF = 1'b0;
    logic [7:0]    DATA = 8'h00;
    logic          W_EN;
    logic [AW-1:0] W_ADDR;
    logic [7:0]    W_DATA;
    logic          FRAME_DONE;
    logic          ROW_ERR;
`ifdef COLOR_STATS_EN
    logic [AW-1:0] RED_CNT, BLUE_CNT;
`endif

    camera_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .VSYNC      (VSYNC),
        .HREF       (HREF),
        .DATA       (DATA),
        .W_EN       (W_EN),
        .W_ADDR     (W_ADDR),
        .W_DATA     (W_DATA),
        .FRAME_DONE (FRAME_DONE),
        .ROW_ERR    (ROW_ERR)
`ifdef COLOR_STATS_EN
        ,
        .RED_CNT    (RED_CNT),
        .BLUE_CNT   (BLUE_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Monitor state
    int         wr_cnt, fd_cnt, re_cnt, seq_bad, data_bad;
    int         first_addr, last_addr, max_addr, exp_next;
    bit         chk_data, chk_seq;
    int         pix_mode;
    logic [7:0] fb [0:32767];

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [8];

    function automatic logic [15:0] pix_of(input int mode, input int x);
        if (mode == 1) return (x < 20) ? 16'h0F00 : 16'h000F;
        case (x / 20)
            0: return 16'h0F00;
            1: return 16'h00F0;
            2: return 16'h000F;
            3: return 16'h0FF0;
            4: return 16'h0F0F;
            5: return 16'h00FF;
            6: return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] exp332(input logic [15:0] p);
        return {p[11:9], p[7:5], p[3:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_cnt = 0; fd_cnt = 0; re_cnt = 0; seq_bad = 0; data_bad = 0;
        first_addr = -1; last_addr = -1; max_addr = -1; exp_next = 0;
    endtask

    // Observe the write port and pulses away from the active edge.
    always @(negedge CLK) begin
        if (W_EN) begin
            wr_cnt++;
            if (first_addr < 0) first_addr = int'(W_ADDR);
            last_addr = int'(W_ADDR);
            if (int'(W_ADDR) > max_addr) max_addr = int'(W_ADDR);
            fb[W_ADDR] = W_DATA;
            if (chk_seq && int'(W_ADDR) != exp_next) seq_bad++;
            exp_next = int'(W_ADDR) + 1;
            if (chk_data && W_DATA !== exp332(pix_of(0, int'(W_ADDR) % W))) data_bad++;
        end
        if (FRAME_DONE) fd_cnt++;
        if (ROW_ERR) re_cnt++;
    end

    task automatic vsync_pulse();
        @(negedge CLK); HREF = 1'b0; VSYNC = 1'b1;
        repeat (3) @(negedge CLK);
        VSYNC = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    // One row of npix pixels, optionally one dangling even byte, optionally
    // raising VSYNC in the same cycle that HREF falls.
    task automatic send_row(input int npix, input bit odd, input bit vs_end);
        logic [15:0] p;
        for (int x = 0; x < npix; x++) begin
            p = pix_of(pix_mode, x);
            @(negedge CLK); HREF = 1'b1; DATA = p[15:8];
            @(negedge CLK); DATA = p[7:0];
        end
        if (odd) begin
            p = pix_of(pix_mode, npix);
            @(negedge CLK); DATA = p[15:8];
        end
        @(negedge CLK); HREF = 1'b0; DATA = 8'h00; VSYNC = vs_end;
    endtask

    task automatic send_rows(input int nrows, input int npix);
        for (int r = 0; r < nrows; r++) begin
            send_row(npix, 1'b0, 1'b0);
            @(negedge CLK);
        end
    endtask

    task automatic check_vec(input int i);
        check($sformatf("tbl%0d_wen", i), W_EN, 1);
        check($sformatf("tbl%0d_addr", i), W_ADDR, i);
        check($sformatf("tbl%0d_data", i), W_DATA, vecs[i].exp);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h0F, 8'h00, 8'hE0};
        vecs[1] = '{8'h00, 8'hF0, 8'h1C};
        vecs[2] = '{8'h00, 8'h0F, 8'h03};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{8'h00, 8'h00, 8'h00};
        vecs[5] = '{8'hA5, 8'hC3, 8'h58};
        vecs[6] = '{8'h07, 8'h89, 8'h72};
        vecs[7] = '{8'h01, 8'h23, 8'h04};
        chk_data = 1'b0; chk_seq = 1'b0; pix_mode = 0;
        clear_mon();

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_wen", W_EN, 0);
        check("rst_addr", W_ADDR, 0);
        check("rst_data", W_DATA, 0);
        check("rst_fdone", FRAME_DONE, 0);
        check("rst_rowerr", ROW_ERR, 0);
`ifdef COLOR_STATS_EN
        check("rst_red", RED_CNT, 0);
        check("rst_blue", BLUE_CNT, 0);
`endif
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Conversion table: one row, one pixel per vector, 1-cycle latency
        vsync_pulse();
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK); HREF = 1'b1; DATA = vecs[i].hi;
            if (i > 0) check_vec(i - 1);
            @(negedge CLK); DATA = vecs[i].lo;
            check("tbl_even_no_wen", W_EN, 0);
        end
        @(negedge CLK); HREF = 1'b0; DATA = 8'h00;
        check_vec(7);
        vsync_pulse();
        check("tbl_writes", wr_cnt, 8);
        check("tbl_fdone", fd_cnt, 1);

        // Full colour-bar frame
        vsync_pulse();
        clear_mon();
        chk_data = 1'b1; chk_seq = 1'b1;
        send_rows(H, W);
        vsync_pulse();
        check("full_writes", wr_cnt, W * H);
        check("full_first", first_addr, 0);
        check("full_last", last_addr, W * H - 1);
        check("full_seq", seq_bad, 0);
        check("full_data", data_bad, 0);
        check("full_fdone", fd_cnt, 1);
        check("full_rowerr", re_cnt, 0);
        check("bar_x0", fb[0], 8'hE0);
        check("bar_x20", fb[20], 8'h1C);
        check("bar_x40", fb[40], 8'h03);
        check("bar_x120", fb[120], 8'hFF);
        check("bar_x150", fb[150], 8'h00);
        check("row1_x0", fb[176], 8'hE0);

        // Odd row: 7 bytes, then a clean 2-pixel row
        vsync_pulse();
        clear_mon();
        chk_seq = 1'b0;
        fb[176] = 8'h55;
        send_row(3, 1'b1, 1'b0);
        @(negedge CLK);
        send_row(2, 1'b0, 1'b0);
        vsync_pulse();
        check("odd_writes", wr_cnt, 5);
        check("odd_rowerr", re_cnt, 1);
        check("odd_first", first_addr, 0);
        check("odd_last", last_addr, 177);
        check("odd_next_row", fb[176], 8'hE0);
        check("odd_fdone", fd_cnt, 1);

        // HREF fall with dangling byte coincident with VSYNC rise
        vsync_pulse();
        clear_mon();
        send_row(4, 1'b0, 1'b0);
        @(negedge CLK);
        send_row(3, 1'b1, 1'b1);
        @(negedge CLK);
        check("coin_rowerr", ROW_ERR, 1);
        check("coin_fdone", FRAME_DONE, 1);
        repeat (3) @(negedge CLK);
        VSYNC = 1'b0;
        repeat (2) @(negedge CLK);
        check("coin_writes", wr_cnt, 7);
        check("coin_fdone_cnt", fd_cnt, 1);

        // Reset in row 50, stream keeps running
        vsync_pulse();
        clear_mon();
        send_rows(50, 4);
        @(negedge CLK); HREF = 1'b1; DATA = 8'h0F;
        @(negedge CLK); DATA = 8'h00;
        @(negedge CLK); DATA = 8'h0F; RESET_N = 1'b0;
        @(negedge CLK); DATA = 8'h00;
        check("mid_rst_wen", W_EN, 0);
        check("mid_rst_addr", W_ADDR, 0);
        check("mid_rst_data", W_DATA, 0);
        check("mid_rst_fdone", FRAME_DONE, 0);
        check("mid_rst_rowerr", ROW_ERR, 0);
        @(negedge CLK); RESET_N = 1'b1; DATA = 8'h0F;
        clear_mon();
        @(negedge CLK); DATA = 8'hF0;
        @(negedge CLK); HREF = 1'b0; DATA = 8'h00;
        @(negedge CLK);
        send_rows(10, 4);
        vsync_pulse();
        check("post_rst_writes", wr_cnt, 0);
        check("post_rst_fdone", fd_cnt, 0);
        send_rows(2, 4);
        vsync_pulse();
        check("restart_writes", wr_cnt, 8);
        check("restart_first", first_addr, 0);
        check("restart_fdone", fd_cnt, 1);

        // Overscan: 150 rows, some 180 pixels wide
        vsync_pulse();
        clear_mon();
        for (int r = 0; r < 150; r++) begin
            send_row((r < 2 || r == 143 || r == 144 || r == 149) ? 180 : 2, 1'b0, 1'b0);
            @(negedge CLK);
        end
        vsync_pulse();
        check("ovs_writes", wr_cnt, 3 * W + 141 * 2);
        check("ovs_max", max_addr, W * H - 1);
        check("ovs_last", last_addr, W * H - 1);
        check("ovs_data", data_bad, 0);
        check("ovs_fdone", fd_cnt, 1);

`ifdef COLOR_STATS_EN
        // 20 red then 20 blue columns over every row
        vsync_pulse();
        clear_mon();
        chk_data = 1'b0;
        pix_mode = 1;
        send_rows(H, 40);
        vsync_pulse();
        check("stats_red", RED_CNT, 2880);
        check("stats_blue", BLUE_CNT, 2880);
        check("stats_fdone", fd_cnt, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
